// File: rtl/hamd_pkg.sv
// Shared definitions for the two-requester Hamming decode arbiter:
// source tags, counter width and the syndrome helper.
package hamd_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  localparam int CNT_W  = 8;
  localparam int MAX_CW = 16;

  // Codeword is right-aligned in 'code': bit cw-1 is position 1, bit 0 is position cw.
  function automatic logic [3:0] syndrome(input logic [MAX_CW-1:0] code, input int cw);
    logic [3:0] s;
    s = '0;
    for (int p = 1; p < MAX_CW; p++) begin
      if (p <= cw) begin
        if (code[4'(cw - p)]) s = s ^ 4'(p);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/hamd_if.sv
// Bundle of the requester, output and statistics signals of hamd_arbiter.
interface hamd_if import hamd_pkg::*; #(
  parameter int IP_BIT = 8
);
  // Every channel is valid/ready: a word moves on a rising edge where both are 1;
  // a producer holds valid and its payload steady until that edge.
  logic              in_valid_a;
  logic [IP_BIT+3:0] in_code_a;
  logic              in_ready_a;
  logic              in_valid_b;
  logic [IP_BIT+3:0] in_code_b;
  logic              in_ready_b;
  logic              out_valid;
  logic [IP_BIT-1:0] out_data;
  logic              out_src;
  logic              out_ready;
  logic [CNT_W-1:0]  err_cnt_a;
  logic [CNT_W-1:0]  err_cnt_b;

  modport slave (
    input  in_valid_a, in_code_a, in_valid_b, in_code_b, out_ready,
    output in_ready_a, in_ready_b, out_valid, out_data, out_src, err_cnt_a, err_cnt_b
  );

  modport master (
    output in_valid_a, in_code_a, in_valid_b, in_code_b, out_ready,
    input  in_ready_a, in_ready_b, out_valid, out_data, out_src, err_cnt_a, err_cnt_b
  );
endinterface

// File: rtl/hamd_arbiter_hamming.sv
// Combinational single-error-correcting Hamming decoder (the shared HAMMING_IP).
// Output packing is {pos3, pos5..7, pos9..IP_BIT+4}.
module hamming_ip import hamd_pkg::*; #(
  parameter int IP_BIT = 8
) (
  input  logic [IP_BIT+3:0] code,
  output logic [IP_BIT-1:0] data
);
  localparam int CW = IP_BIT + 4;

  logic [3:0]    syn;
  logic [CW-1:0] fixed;

  always_comb begin
    syn   = syndrome(MAX_CW'(code), CW);
    fixed = code;
    // Syndromes beyond the codeword length match no position and leave it untouched.
    for (int p = 1; p <= CW; p++) begin
      if (syn == 4'(p)) fixed[4'(CW - p)] = ~code[4'(CW - p)];
    end
    data = '0;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) data = {data[IP_BIT-2:0], fixed[4'(CW - p)]};
    end
  end
endmodule

// File: rtl/hamd_arbiter.sv
// Round-robin arbiter feeding two codeword sources through a 2-stage decode pipeline.
// Define HAMD_ERR_STAT_EN to build the per-source corrected-error counters.
module hamd_arbiter import hamd_pkg::*; #(
  parameter int IP_BIT = 8
) (
  input logic   clk,
  input logic   rst,
  hamd_if.slave bus
);
  localparam int CW = IP_BIT + 4;

  logic              adv0;
  logic              adv1;
  logic              grant_a;
  logic              grant_b;
  logic              s0_valid;
  logic [CW-1:0]     s0_code;
  src_t              s0_src;
  src_t              last_grant;
  logic [IP_BIT-1:0] dec_data;

  always_comb begin
    adv1    = !bus.out_valid || bus.out_ready;
    adv0    = !s0_valid || adv1;
    grant_a = bus.in_valid_a && (!bus.in_valid_b || last_grant == SRC_B);
    grant_b = bus.in_valid_b && (!bus.in_valid_a || last_grant == SRC_A);
    bus.in_ready_a = !rst && adv0 && grant_a;
    bus.in_ready_b = !rst && adv0 && grant_b;
  end

  // S0: accepted codeword; a cycle with no grant loads a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid   <= 1'b0;
      s0_code    <= '0;
      s0_src     <= SRC_A;
      last_grant <= SRC_B;
    end else if (adv0) begin
      s0_valid <= bus.in_ready_a || bus.in_ready_b;
      if (bus.in_ready_a || bus.in_ready_b) begin
        s0_code    <= bus.in_ready_a ? bus.in_code_a : bus.in_code_b;
        s0_src     <= bus.in_ready_a ? SRC_A : SRC_B;
        last_grant <= bus.in_ready_a ? SRC_A : SRC_B;
      end
    end
  end

  hamming_ip #(.IP_BIT(IP_BIT)) u_dec (
    .code (s0_code),
    .data (dec_data)
  );

  // S1: output register, frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= 1'b0;
    end else if (adv1) begin
      bus.out_valid <= s0_valid;
      if (s0_valid) begin
        bus.out_data <= dec_data;
        bus.out_src  <= s0_src;
      end
    end
  end

`ifdef HAMD_ERR_STAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       stat_syn;
  logic             move_err;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  always_comb begin
    stat_syn = syndrome(MAX_CW'(s0_code), CW);
    move_err = adv1 && s0_valid && (stat_syn != 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (move_err) begin
      if (s0_src == SRC_A && cnt_a != CNT_MAX) cnt_a <= cnt_a + CNT_W'(1);
      if (s0_src == SRC_B && cnt_b != CNT_MAX) cnt_b <= cnt_b + CNT_W'(1);
    end
  end

  assign bus.err_cnt_a = cnt_a;
  assign bus.err_cnt_b = cnt_b;
`else
  assign bus.err_cnt_a = '0;
  assign bus.err_cnt_b = '0;
`endif

endmodule

// File: tb/tb_hamd_arbiter.sv
// Bench for hamd_arbiter: queue-based reference of the arbitration and pipeline
// occupancy, encoder-generated words with optional single-bit corruption.
module tb_hamd_arbiter;
  localparam int IP_BIT = 8;
  localparam int CW     = 12;
  localparam int W      = 10;   // expected entry: {corrupt, src, data}
`ifdef HAMD_ERR_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hamd_if #(.IP_BIT(IP_BIT)) bus ();
  hamd_arbiter #(.IP_BIT(IP_BIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- word generation ----------------
  function automatic logic [CW-1:0] encode(input logic [7:0] d);
    logic [CW-1:0] c;
    logic [3:0]    par;
    int            k;
    c = '0; par = '0; k = 7;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[3'(k)]) begin
          c[4'(CW - p)] = 1'b1;
          par = par ^ 4'(p);
        end
        k--;
      end
    end
    for (int i = 0; i < 4; i++) if (par[i]) c[4'(CW - (1 << i))] = 1'b1;
    return c;
  endfunction

  // word layout: [20] corrupt, [19:12] data, [11:0] codeword
  function automatic logic [20:0] make_word(input logic [7:0] d, input logic cor);
    logic [CW-1:0] c;
    int            p;
    c = encode(d);
    if (cor) begin
      p = $urandom_range(1, CW);
      c[4'(CW - p)] = ~c[4'(CW - p)];
    end
    return {cor, d, c};
  endfunction

  // ---------------- drivers ----------------
  logic [20:0] dq_a[$];
  logic [20:0] dq_b[$];
  logic [20:0] cur_a, cur_b;
  logic        hs_a = 1'b0, hs_b = 1'b0;
  bit          rand_en = 1'b0;
  int          pct_a = 60, pct_b = 60, pct_cor = 40;

  task automatic push_a(input logic [20:0] w); dq_a.push_back(w); endtask
  task automatic push_b(input logic [20:0] w); dq_b.push_back(w); endtask

  always @(posedge clk) begin
    #2;
    if (bus.in_valid_a !== 1'b1 || hs_a) begin
      if (dq_a.size() > 0) begin
        cur_a = dq_a.pop_front();
        bus.in_valid_a = 1'b1;
      end else if (rand_en && $urandom_range(99) < pct_a) begin
        cur_a = make_word(8'($urandom), $urandom_range(99) < pct_cor);
        bus.in_valid_a = 1'b1;
      end else begin
        cur_a = '0;
        bus.in_valid_a = 1'b0;
      end
      bus.in_code_a = cur_a[11:0];
    end
    if (bus.in_valid_b !== 1'b1 || hs_b) begin
      if (dq_b.size() > 0) begin
        cur_b = dq_b.pop_front();
        bus.in_valid_b = 1'b1;
      end else if (rand_en && $urandom_range(99) < pct_b) begin
        cur_b = make_word(8'($urandom), $urandom_range(99) < pct_cor);
        bus.in_valid_b = 1'b1;
      end else begin
        cur_b = '0;
        bus.in_valid_b = 1'b0;
      end
      bus.in_code_b = cur_b[11:0];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [7:0]   log_data[$];
  logic         log_src[$];
  int           log_e[$];
  int           log_lat[$];
  int           e_cnt = 0;
  logic         last_win = 1'b1;
  int           cor_a = 0, cor_b = 0;
  bit           head_seen = 1'b0;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  always @(posedge clk) e_cnt++;

  always @(negedge clk) begin
    int           n;
    logic         vis, va, vb, free, ga, gb;
    logic [W-1:0] h;
    int           ea, eb;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      last_win  = 1'b1;
      cor_a     = 0;
      cor_b     = 0;
      head_seen = 1'b0;
      hs_a      = 1'b0;
      hs_b      = 1'b0;
      chk("rst_in_ready_a", bus.in_ready_a, 0);
      chk("rst_in_ready_b", bus.in_ready_b, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_err_cnt_a", bus.err_cnt_a, 0);
      chk("rst_err_cnt_b", bus.err_cnt_b, 0);
    end else begin
      n   = exp_q.size();
      vis = (n > 0) && (acc_q[0] <= e_cnt - 1);
      h   = (n > 0) ? exp_q[0] : '0;
      va  = (bus.in_valid_a === 1'b1);
      vb  = (bus.in_valid_b === 1'b1);
      // Two words in flight and a stalled consumer leave no room for a third.
      free = !((n >= 2) && !bus.out_ready);
      ga   = free && va && (!vb || last_win == 1'b1);
      gb   = free && vb && (!va || last_win == 1'b0);
      chk("in_ready_a", bus.in_ready_a, ga);
      chk("in_ready_b", bus.in_ready_b, gb);
      chk("out_valid", bus.out_valid, vis);
      if (vis) begin
        chk("out_data", bus.out_data, h[7:0]);
        chk("out_src", bus.out_src, h[8]);
        if (!head_seen) begin
          log_lat.push_back(e_cnt - acc_q[0]);
          head_seen = 1'b1;
        end
      end
      ea = STAT ? sat(cor_a + ((vis && h[9] && !h[8]) ? 1 : 0)) : 0;
      eb = STAT ? sat(cor_b + ((vis && h[9] &&  h[8]) ? 1 : 0)) : 0;
      chk("err_cnt_a", bus.err_cnt_a, ea);
      chk("err_cnt_b", bus.err_cnt_b, eb);
      if (vis && bus.out_ready) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        log_data.push_back(h[7:0]);
        log_src.push_back(h[8]);
        log_e.push_back(e_cnt);
        if (h[9] && !h[8]) cor_a++;
        if (h[9] &&  h[8]) cor_b++;
        head_seen = 1'b0;
      end
      if (ga) begin
        exp_q.push_back({cur_a[20], 1'b0, cur_a[19:12]});
        acc_q.push_back(e_cnt + 1);
        last_win = 1'b0;
      end
      if (gb) begin
        exp_q.push_back({cur_b[20], 1'b1, cur_b[19:12]});
        acc_q.push_back(e_cnt + 1);
        last_win = 1'b1;
      end
      hs_a = (bus.in_valid_a === 1'b1) && (bus.in_ready_a === 1'b1);
      hs_b = (bus.in_valid_b === 1'b1) && (bus.in_ready_b === 1'b1);
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((dq_a.size() > 0 || dq_b.size() > 0 || bus.in_valid_a === 1'b1 ||
            bus.in_valid_b === 1'b1 || exp_q.size() > 0) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, (k < 3000) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    dq_a.delete();
    dq_b.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    int          n;
    logic [7:0]  bp_d[4];
    logic [7:0]  rs_d[4];
    bp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    rs_d = '{8'h55, 8'h66, 8'h77, 8'h88};
    rst = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_out_data", bus.out_data, 0);
    chk("init_out_src", bus.out_src, 0);
    chk("init_in_ready_a", bus.in_ready_a, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // clean word from A
    push_a({1'b0, 8'hA5, 12'hE45});
    wait_drain("drain_t1");
    n = log_data.size();
    chk("t1_data", log_data[n-1], 8'hA5);
    chk("t1_src", log_src[n-1], 0);
    chk("t1_latency", log_lat[log_lat.size()-1], 1);
    chk("t1_err_a", bus.err_cnt_a, 0);

    // position 6 flipped
    push_a({1'b1, 8'hA5, 12'hE05});
    wait_drain("drain_t2");
    n = log_data.size();
    chk("t2_data", log_data[n-1], 8'hA5);
    chk("t2_err_a", bus.err_cnt_a, STAT ? 1 : 0);

    // continuous contention after reset: A first, strict alternation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_a(make_word(8'($urandom), 1'b0));
      push_b(make_word(8'($urandom), 1'b0));
    end
    wait_drain("drain_t3");
    n = log_src.size();
    for (int i = 0; i < 6; i++) begin
      chk("t3_src_order", log_src[n-6+i], i % 2);
      chk("t3_back_to_back", log_e[n-6+i] - log_e[n-6], i);
    end

    // backpressure: 4 stalled cycles while A streams
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_a(make_word(bp_d[i], 1'b0));
    repeat (3) @(negedge clk);
    #1;
    chk("bp_ready_a_3rd", bus.in_ready_a, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    @(posedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain("drain_t4");
    n = log_data.size();
    for (int i = 0; i < 4; i++) chk("bp_order", log_data[n-4+i], bp_d[i]);

    // reset with both stages full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_a(make_word(rs_d[i], 1'b0));
    repeat (3) @(posedge clk); #1;
    chk("rs_full_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    dq_a.delete();
    push_b(make_word(8'h99, 1'b0));
    #1;
    chk("rs_out_valid_now", bus.out_valid, 0);
    chk("rs_ready_a_now", bus.in_ready_a, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    n = log_data.size();
    wait_drain("drain_t5");
    chk("rs_count", log_data.size() - n, 2);
    chk("rs_first_src", log_src[n], 0);
    chk("rs_first_data", log_data[n], 8'h77);
    chk("rs_second_src", log_src[n+1], 1);
    chk("rs_second_data", log_data[n+1], 8'h99);

    // randomized traffic with random consumer stalls
    rand_en = 1'b1;
    repeat (1500) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(99) < 70);
    end
    rand_en = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("drain_rand");

    // counter saturation on B
    do_reset();
    for (int i = 0; i < 300; i++) push_b(make_word(8'($urandom), 1'b1));
    wait_drain("drain_sat");
    chk("sat_err_b", bus.err_cnt_b, STAT ? 255 : 0);
    chk("sat_err_a", bus.err_cnt_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
